// File: rtl/controlador_cafe_param.sv
`default_nettype none
// ============================================================================
//  Module   : controlador_cafe_param
//  Purpose  : Top-level control FSM of a coffee machine. It heats the
//             thermoblock, unlocks operation with an access code (with a
//             retry lockout), serves one of N_SEL drinks with per-drink water
//             use and pump time, and tracks the reservoir level and refills.
//  Ports    : CLK, RST_N (async, active low)
//             power, codigo/codigo_valid, selecao, start, refill   (inputs)
//             termobloco, bomba, reservatorio, estado, erro,
//             bloqueado                                            (outputs)
//  Revision : 1.0  initial release
// ============================================================================
module controlador_cafe_param #(
    parameter int                CODE_W    = 7,
    parameter logic [CODE_W-1:0] CODE      = 7'd17,
    parameter int                SEL_W     = 2,
    parameter int                N_SEL     = 4,
    parameter int                HEAT_CYC  = 5,
    parameter int                POUR_CYC  = 3,
    parameter int                LEVEL_W   = 4,
    parameter int                LEVEL_MAX = 15,
    parameter int                MAX_TRIES = 3,
    parameter int                LOCK_CYC  = 10
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               power,
    input  logic [CODE_W-1:0]  codigo,
    input  logic               codigo_valid,
    input  logic [SEL_W-1:0]   selecao,
    input  logic               start,
    input  logic               refill,
    output logic               termobloco,
    output logic               bomba,
    output logic [LEVEL_W-1:0] reservatorio,
    output logic [3:0]         estado,
    output logic               erro,
    output logic               bloqueado
);

    localparam int HEAT_W = $clog2(HEAT_CYC + 1);
    localparam int LOCK_W = $clog2(LOCK_CYC + 1);
    localparam int POUR_W = $clog2(N_SEL * POUR_CYC + 1);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);

    localparam logic [HEAT_W-1:0]  c_heat_last = HEAT_W'(HEAT_CYC - 1);
    localparam logic [LOCK_W-1:0]  c_lock_last = LOCK_W'(LOCK_CYC - 1);
    localparam logic [TRY_W-1:0]   c_tries_max = TRY_W'(MAX_TRIES);
    localparam logic [LEVEL_W-1:0] c_level_max = LEVEL_W'(LEVEL_MAX);
    localparam logic [SEL_W:0]     c_n_sel     = (SEL_W + 1)'(N_SEL);

    typedef enum logic [3:0] {
        ST_OFF      = 4'd0,
        ST_AQUECER  = 4'd1,
        ST_ESPERA   = 4'd2,
        ST_BLOQUEIO = 4'd3,
        ST_SELECAO  = 4'd4,
        ST_SERVIR   = 4'd5,
        ST_FIM      = 4'd6,
        ST_SEM_AGUA = 4'd7
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [HEAT_W-1:0]    r_heat_cnt;
    logic [LOCK_W-1:0]    r_lock_cnt;
    logic [POUR_W-1:0]    r_pour_cnt;
    logic [TRY_W-1:0]     r_tries;
    logic [TRY_W-1:0]     w_tries_next;
    logic [TRY_W-1:0]     w_tries_inc;
    logic [LEVEL_W-1:0]   r_level;
    logic [LEVEL_W-1:0]   w_level_next;
    logic [LEVEL_W-1:0]   w_level_eff;
    logic [LEVEL_W-1:0]   w_need;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     w_sel_next;
    logic [POUR_W-1:0]    w_pour_last;
    logic                 r_start_prev;
    logic                 w_start_rise;
    logic                 w_sel_ok;
    logic                 w_erro_pulse;
    logic                 r_termobloco;
    logic                 r_bomba;
    logic                 r_erro;
    logic                 r_bloqueado;

    // Refill is ignored while pouring; elsewhere it takes effect before the
    // level check so a simultaneous start sees a full reservoir.
    assign w_level_eff  = (refill && (r_state != ST_SERVIR)) ? c_level_max : r_level;
    assign w_start_rise = start && !r_start_prev;
    assign w_sel_ok     = {1'b0, selecao} < c_n_sel;
    assign w_need       = LEVEL_W'(selecao) + LEVEL_W'(1);
    assign w_tries_inc  = r_tries + TRY_W'(1);
    assign w_pour_last  = (POUR_W'(r_sel) + POUR_W'(1)) * POUR_W'(POUR_CYC) - POUR_W'(1);

    always_comb begin
        w_next_state = r_state;
        w_tries_next = r_tries;
        w_level_next = w_level_eff;
        w_sel_next   = r_sel;
        w_erro_pulse = 1'b0;

        case (r_state)
            ST_OFF: begin
                if (power) w_next_state = ST_AQUECER;
            end
            ST_AQUECER: begin
                if (r_heat_cnt == c_heat_last) w_next_state = ST_ESPERA;
            end
            ST_ESPERA: begin
                if (codigo_valid) begin
                    if (codigo == CODE) begin
                        w_tries_next = '0;
                        w_next_state = ST_SELECAO;
                    end else begin
                        w_erro_pulse = 1'b1;
                        w_tries_next = w_tries_inc;
                        if (w_tries_inc == c_tries_max) w_next_state = ST_BLOQUEIO;
                    end
                end
            end
            ST_BLOQUEIO: begin
                if (r_lock_cnt == c_lock_last) begin
                    w_tries_next = '0;
                    w_next_state = power ? ST_ESPERA : ST_OFF;
                end
            end
            ST_SELECAO: begin
                if (w_start_rise) begin
                    if (!w_sel_ok) begin
                        w_erro_pulse = 1'b1;
                    end else if (w_level_eff < w_need) begin
                        w_next_state = ST_SEM_AGUA;
                    end else begin
                        w_sel_next   = selecao;
                        w_level_next = w_level_eff - w_need;
                        w_next_state = ST_SERVIR;
                    end
                end
            end
            ST_SERVIR: begin
                if (r_pour_cnt == w_pour_last) w_next_state = ST_FIM;
            end
            ST_FIM: begin
                if (!start) w_next_state = ST_SELECAO;
            end
            ST_SEM_AGUA: begin
                if (refill) w_next_state = ST_SELECAO;
            end
            default: w_next_state = ST_OFF;
        endcase

        // Power loss overrides everything except the lockout, which must run
        // to completion. Level (including any refill) and tries are kept.
        if (!power && (r_state != ST_BLOQUEIO)) begin
            w_next_state = ST_OFF;
            w_tries_next = r_tries;
            w_level_next = w_level_eff;
            w_sel_next   = r_sel;
            w_erro_pulse = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_OFF;
            r_heat_cnt   <= '0;
            r_lock_cnt   <= '0;
            r_pour_cnt   <= '0;
            r_tries      <= '0;
            r_level      <= c_level_max;
            r_sel        <= '0;
            r_start_prev <= 1'b0;
            r_termobloco <= 1'b0;
            r_bomba      <= 1'b0;
            r_erro       <= 1'b0;
            r_bloqueado  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_tries      <= w_tries_next;
            r_level      <= w_level_next;
            r_sel        <= w_sel_next;
            r_start_prev <= start;
            // Each timer runs only while its state persists; any transition
            // (including a forced power-off) restarts it from zero.
            r_heat_cnt   <= (r_state == ST_AQUECER && w_next_state == ST_AQUECER)
                            ? r_heat_cnt + HEAT_W'(1) : '0;
            r_lock_cnt   <= (r_state == ST_BLOQUEIO && w_next_state == ST_BLOQUEIO)
                            ? r_lock_cnt + LOCK_W'(1) : '0;
            r_pour_cnt   <= (r_state == ST_SERVIR && w_next_state == ST_SERVIR)
                            ? r_pour_cnt + POUR_W'(1) : '0;
            // Outputs are registered from the next state so they change on
            // the edge that enters a state. The heater stays on in every
            // powered-up state so the block remains hot while serving.
            r_termobloco <= (w_next_state != ST_OFF);
            r_bomba      <= (w_next_state == ST_SERVIR);
            r_bloqueado  <= (w_next_state == ST_BLOQUEIO);
            r_erro       <= w_erro_pulse || (w_next_state == ST_SEM_AGUA);
        end
    end

    assign termobloco   = r_termobloco;
    assign bomba        = r_bomba;
    assign reservatorio = r_level;
    assign estado       = r_state;
    assign erro         = r_erro;
    assign bloqueado    = r_bloqueado;

endmodule
`default_nettype wire

// File: tb/tb_controlador_cafe_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controlador_cafe_param
//  Purpose  : Self-checking bench for controlador_cafe_param. A behavioural
//             model (countdown timers, integer level) predicts every output
//             each cycle; directed scenarios add literal expectations, then
//             randomized stimulus exercises the remaining space.
//  Revision : 1.0  initial release
// ============================================================================
module tb_controlador_cafe_param;

    localparam int         CODE_W    = 7;
    localparam logic [6:0] CODE      = 7'd17;
    localparam int         SEL_W     = 2;
    localparam int         N_SEL     = 3;
    localparam int         HEAT_CYC  = 5;
    localparam int         POUR_CYC  = 3;
    localparam int         LEVEL_W   = 4;
    localparam int         LEVEL_MAX = 15;
    localparam int         MAX_TRIES = 3;
    localparam int         LOCK_CYC  = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       power = 1'b0;
    logic [6:0] codigo = '0;
    logic       codigo_valid = 1'b0;
    logic [1:0] selecao = '0;
    logic       start = 1'b0;
    logic       refill = 1'b0;
    logic       termobloco, bomba, erro, bloqueado;
    logic [3:0] reservatorio, estado;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    controlador_cafe_param #(
        .CODE_W(CODE_W), .CODE(CODE), .SEL_W(SEL_W), .N_SEL(N_SEL),
        .HEAT_CYC(HEAT_CYC), .POUR_CYC(POUR_CYC), .LEVEL_W(LEVEL_W),
        .LEVEL_MAX(LEVEL_MAX), .MAX_TRIES(MAX_TRIES), .LOCK_CYC(LOCK_CYC)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .power(power), .codigo(codigo),
        .codigo_valid(codigo_valid), .selecao(selecao), .start(start),
        .refill(refill), .termobloco(termobloco), .bomba(bomba),
        .reservatorio(reservatorio), .estado(estado), .erro(erro),
        .bloqueado(bloqueado)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_st holds the observable mode number; m_left counts remaining cycles.
    int m_st = 0, m_left = 0, m_level = LEVEL_MAX, m_tries = 0;
    bit m_prev = 1'b0, m_pulse = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int lvl, nst, sel;
        bit rise;
        if (!rst_n) begin
            m_st = 0; m_left = 0; m_level = LEVEL_MAX; m_tries = 0;
            m_prev = 1'b0; m_pulse = 1'b0;
        end else begin
            rise    = start && !m_prev;
            lvl     = (refill && m_st != 5) ? LEVEL_MAX : m_level;
            sel     = int'(selecao);
            nst     = m_st;
            m_pulse = 1'b0;
            if (!power && m_st != 3) begin
                nst = 0;
            end else begin
                case (m_st)
                    0: begin nst = 1; m_left = HEAT_CYC; end
                    1: begin m_left--; if (m_left == 0) nst = 2; end
                    2: if (codigo_valid) begin
                        if (codigo == CODE) begin m_tries = 0; nst = 4; end
                        else begin
                            m_pulse = 1'b1;
                            m_tries++;
                            if (m_tries == MAX_TRIES) begin nst = 3; m_left = LOCK_CYC; end
                        end
                    end
                    3: begin
                        m_left--;
                        if (m_left == 0) begin m_tries = 0; nst = power ? 2 : 0; end
                    end
                    4: if (rise) begin
                        if (sel >= N_SEL) m_pulse = 1'b1;
                        else if (lvl < sel + 1) nst = 7;
                        else begin
                            lvl    = lvl - (sel + 1);
                            nst    = 5;
                            m_left = (sel + 1) * POUR_CYC;
                        end
                    end
                    5: begin m_left--; if (m_left == 0) nst = 6; end
                    6: if (!start) nst = 4;
                    7: if (refill) nst = 4;
                    default: nst = 0;
                endcase
            end
            m_st    = nst;
            m_level = lvl;
            m_prev  = start;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit e_term, e_bomba, e_err, e_bloq;
        if (chk_on) begin
            e_term  = (m_st != 0);
            e_bomba = (m_st == 5);
            e_bloq  = (m_st == 3);
            e_err   = m_pulse || (m_st == 7);
            vectors++;
            if (estado !== 4'(m_st) || reservatorio !== 4'(m_level) ||
                termobloco !== e_term || bomba !== e_bomba ||
                erro !== e_err || bloqueado !== e_bloq) begin
                miscompares++;
                $display("FAIL model t=%0t: got est=%0d lvl=%0d heat=%b pump=%b err=%b lock=%b, expected est=%0d lvl=%0d heat=%b pump=%b err=%b lock=%b",
                         $time, estado, reservatorio, termobloco, bomba, erro, bloqueado,
                         m_st, m_level, e_term, e_bomba, e_err, e_bloq);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic enter_code(input logic [6:0] c);
        codigo = c; codigo_valid = 1'b1;
        tick();
        codigo_valid = 1'b0;
    endtask

    task automatic wait_state(input int s, input int bound);
        for (int i = 0; i < bound && int'(estado) != s; i++) tick();
        chk("wait_state", int'(estado), s);
    endtask

    task automatic serve(input int sel);
        selecao = 2'(sel); start = 1'b1;
        tick();
        wait_state(6, 40);
        start = 1'b0;
        tick();
        chk("serve_back", int'(estado), 4);
    endtask

    task automatic wrong_codes_to_lock();
        for (int i = 0; i < MAX_TRIES; i++) begin
            enter_code(7'd19);
            chk("erro_pulse", int'(erro), 1);
        end
        chk("lock_state", int'(estado), 3);
        chk("bloqueado", int'(bloqueado), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int cnt;
        tick(); tick();
        chk("rst_estado", int'(estado), 0);
        chk("rst_level", int'(reservatorio), 15);
        chk("rst_bomba", int'(bomba), 0);
        chk("rst_erro", int'(erro), 0);
        chk_on = 1'b1;
        rst_n = 1'b1;
        tick();

        // Power-up: five cycles of heating, then waiting for the code.
        power = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (estado == 4'd1) begin
                cnt++;
                chk("heater_on", int'(termobloco), 1);
            end else break;
        end
        chk("heat_cycles", cnt, 5);
        chk("after_heat", int'(estado), 2);

        // Lockout after three wrong codes, ten cycles long.
        wrong_codes_to_lock();
        cnt = 0;
        while (estado == 4'd3 && cnt < 30) begin cnt++; tick(); end
        chk("lock_cycles", cnt, 10);
        chk("after_lock", int'(estado), 2);
        chk("erro_cleared", int'(erro), 0);
        enter_code(CODE);
        chk("unlocked", int'(estado), 4);

        // Serve drink 2: nine pump cycles, level 15 -> 12.
        selecao = 2'd2; start = 1'b1;
        tick();
        chk("serve_state", int'(estado), 5);
        chk("serve_level", int'(reservatorio), 12);
        cnt = 0;
        while (bomba && cnt < 50) begin cnt++; tick(); end
        chk("pump_cycles", cnt, 9);
        chk("fim_state", int'(estado), 6);
        tick(); tick();
        chk("fim_hold", int'(estado), 6);
        start = 1'b0;
        tick();
        chk("back_selecao", int'(estado), 4);

        // New edge serves again; power drops mid-pour.
        start = 1'b1;
        tick();
        chk("serve2", int'(estado), 5);
        tick(); tick();
        power = 1'b0;
        tick();
        chk("pwr_off_state", int'(estado), 0);
        chk("pwr_off_pump", int'(bomba), 0);
        chk("pwr_off_level", int'(reservatorio), 9);
        power = 1'b1; start = 1'b0;
        wait_state(2, 20);
        enter_code(CODE);
        chk("unlocked2", int'(estado), 4);

        // Invalid selection.
        selecao = 2'd3; start = 1'b1;
        tick();
        chk("inval_erro", int'(erro), 1);
        chk("inval_state", int'(estado), 4);
        start = 1'b0;
        tick();
        chk("inval_pulse_end", int'(erro), 0);

        // Drain to level 2, then ask for three units.
        serve(2); serve(2); serve(0);
        chk("level_two", int'(reservatorio), 2);
        selecao = 2'd2; start = 1'b1;
        tick();
        chk("empty_state", int'(estado), 7);
        chk("empty_erro", int'(erro), 1);
        chk("empty_pump", int'(bomba), 0);
        tick();
        chk("empty_erro_held", int'(erro), 1);
        start = 1'b0; refill = 1'b1;
        tick();
        chk("refill_state", int'(estado), 4);
        chk("refill_level", int'(reservatorio), 15);
        refill = 1'b0;

        // Refill coincident with a start edge is seen by the level check.
        serve(2); serve(2); serve(2); serve(2);
        chk("level_three", int'(reservatorio), 3);
        selecao = 2'd2; refill = 1'b1; start = 1'b1;
        tick();
        refill = 1'b0;
        chk("refill_start_state", int'(estado), 5);
        chk("refill_start_level", int'(reservatorio), 12);
        wait_state(6, 40);
        start = 1'b0;
        tick();

        // Lockout survives power loss, then falls to OFF.
        power = 1'b0; tick(); power = 1'b1;
        wait_state(2, 20);
        wrong_codes_to_lock();
        power = 1'b0;
        cnt = 0;
        while (estado == 4'd3 && cnt < 30) begin cnt++; tick(); end
        chk("lock_pwr_cycles", cnt, 10);
        chk("lock_pwr_off", int'(estado), 0);

        // Asynchronous reset between clock edges during a pour.
        power = 1'b1;
        wait_state(2, 20);
        enter_code(CODE);
        selecao = 2'd1; start = 1'b1;
        tick();
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pump", int'(bomba), 0);
        chk("arst_state", int'(estado), 0);
        chk("arst_level", int'(reservatorio), 15);
        chk("arst_heat", int'(termobloco), 0);
        tick();
        rst_n = 1'b1;

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            tick();
            power        = ($urandom_range(0, 99) < 96);
            codigo_valid = ($urandom_range(0, 99) < 12);
            codigo       = ($urandom_range(0, 1) == 1) ? CODE : 7'($urandom);
            if ($urandom_range(0, 99) < 20) start = ~start;
            selecao      = 2'($urandom);
            refill       = ($urandom_range(0, 99) < 3);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
